// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 4-digit common-anode
// 7-segment display. One shared decoder; each digit is lit for DWELL cycles
// followed by an all-off GAP. New values are staged in a shadow register and
// only committed at frame boundaries (or immediately while idle).
module seg_scan_ctrl #(
    parameter int DWELL = 1000,
    parameter int GAP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] load_data,
    input  logic [3:0]  blank_mask,
    output logic        ready,
    output logic [3:0]  nibble_out,
    output logic [3:0]  digit_sel,
    output logic        frame_done
);

    localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] active_q, active_d;
    logic [15:0] pending_q, pending_d;
    logic        pv_q, pv_d;
    logic        ready_q, ready_d;
    logic [3:0]  nib_q, nib_d;
    logic [3:0]  sel_q, sel_d;
    logic        fd_q, fd_d;

    logic        dwell_done, gap_done, wrap, commit;
    logic [15:0] next_active;
    logic [1:0]  idx_nxt;

    // Active-low enable for one digit, forced dark when that digit is blanked.
    function automatic logic [3:0] sel_for(input logic [1:0] i, input logic [3:0] blank);
        logic [3:0] s;
        s = 4'b1111;
        if (!blank[i]) s[i] = 1'b0;
        return s;
    endfunction

    // Next-state, commit and handshake logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        nib_d     = nib_q;
        sel_d     = sel_q;
        fd_d      = 1'b0;
        pending_d = pending_q;
        pv_d      = pv_q;

        dwell_done = (cnt_q == CW'(DWELL - 1));
        gap_done   = (cnt_q == CW'(GAP - 1));
        idx_nxt    = idx_q + 2'd1;
        wrap       = (state_q == S_GAP) && enable && gap_done && (idx_q == 2'd3);
        commit     = pv_q && ((state_q == S_IDLE) || wrap);

        // The value being committed on this edge is what digit 0 must show next.
        next_active = commit ? pending_q : active_q;
        active_d    = next_active;
        if (commit) pv_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                sel_d = 4'b1111;
                if (enable) begin
                    state_d = S_ON;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    nib_d   = next_active[3:0];
                    sel_d   = sel_for(2'd0, blank_mask);
                end
            end
            S_ON: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    sel_d   = 4'b1111;
                end else if (dwell_done) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    sel_d   = 4'b1111;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    sel_d = sel_for(idx_q, blank_mask);
                end
            end
            S_GAP: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    sel_d   = 4'b1111;
                end else if (gap_done) begin
                    state_d = S_ON;
                    idx_d   = idx_nxt;
                    cnt_d   = '0;
                    nib_d   = next_active[idx_nxt*4 +: 4];
                    sel_d   = sel_for(idx_nxt, blank_mask);
                    fd_d    = (idx_q == 2'd3);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
                cnt_d   = '0;
                sel_d   = 4'b1111;
            end
        endcase

        // ready lags the shadow register by one cycle so it rises after commit.
        if (load && ready_q) begin
            pending_d = load_data;
            pv_d      = 1'b1;
            ready_d   = 1'b0;
        end else begin
            ready_d = ~pv_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            active_q  <= 16'h0;
            pending_q <= 16'h0;
            pv_q      <= 1'b0;
            ready_q   <= 1'b1;
            nib_q     <= 4'h0;
            sel_q     <= 4'b1111;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pv_q      <= pv_d;
            ready_q   <= ready_d;
            nib_q     <= nib_d;
            sel_q     <= sel_d;
            fd_q      <= fd_d;
        end
    end

    assign ready      = ready_q;
    assign nibble_out = nib_q;
    assign digit_sel  = sel_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with DWELL=3, GAP=1 (16-cycle frame). Expected lit
// digits are queued up front; a monitor pops one entry each time a digit
// enable goes low and compares select and nibble.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] load_data;
    logic [3:0]  blank_mask;
    logic        ready;
    logic [3:0]  nibble_out;
    logic [3:0]  digit_sel;
    logic        frame_done;

    seg_scan_ctrl #(.DWELL(3), .GAP(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .load_data(load_data), .blank_mask(blank_mask), .ready(ready),
        .nibble_out(nibble_out), .digit_sel(digit_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sel;
        logic [3:0] nib;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  fc = 0;
    logic [3:0] prev_sel = 4'hF;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] s, input logic [3:0] n);
        ev_t e;
        e.sel = s;
        e.nib = n;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        fc++;
    endtask

    task automatic adv_to(input int n);
        while (fc < n) tick();
    endtask

    // Tick until frame_done, checking how many cycles it took.
    task automatic wait_fd(input int exp_ticks);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_done && n < 40);
        chk("frame_done_period", 16'(n), 16'(exp_ticks));
        fc = 1;
    endtask

    // Monitor: every newly lit digit must match the next queued expectation.
    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            prev_sel = 4'hF;
        end else begin
            if (digit_sel != 4'hF && prev_sel == 4'hF) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_digit: got sel=%b nib=%h with nothing expected",
                             digit_sel, nibble_out);
                end else begin
                    e = exp_q.pop_front();
                    if (digit_sel !== e.sel || nibble_out !== e.nib) begin
                        errors++;
                        $display("FAIL digit_scan: got sel=%b nib=%h expected sel=%b nib=%h",
                                 digit_sel, nibble_out, e.sel, e.nib);
                    end
                end
            end
            prev_sel = digit_sel;
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0; load_data = 16'h0; blank_mask = 4'h0;

        // frame 1 and 2 show 0x1234
        for (int f = 0; f < 2; f++) begin
            push(4'b1110, 4'h4); push(4'b1101, 4'h3);
            push(4'b1011, 4'h2); push(4'b0111, 4'h1);
        end
        // frame 3 shows 0xABCD, frame 4 the same with digit 2 blanked
        push(4'b1110, 4'hD); push(4'b1101, 4'hC);
        push(4'b1011, 4'hB); push(4'b0111, 4'hA);
        push(4'b1110, 4'hD); push(4'b1101, 4'hC); push(4'b0111, 4'hA);
        // frame 5 digits 0,1 before enable drop, then restart at digit 0
        push(4'b1110, 4'hD); push(4'b1101, 4'hC);
        push(4'b1110, 4'hD);

        tick(); tick();
        rst = 1'b0;
        chk("reset_ready", 16'(ready), 16'h1);
        chk("reset_sel", 16'(digit_sel), 16'hF);
        chk("reset_nib", 16'(nibble_out), 16'h0);
        chk("reset_fd", 16'(frame_done), 16'h0);

        // idle load: ready low for two cycles, then high
        tick();
        load = 1'b1; load_data = 16'h1234;
        tick();
        load = 1'b0;
        chk("idle_ready_c1", 16'(ready), 16'h0);
        tick();
        chk("idle_ready_c2", 16'(ready), 16'h0);
        tick();
        chk("idle_ready_c3", 16'(ready), 16'h1);
        chk("idle_sel_dark", 16'(digit_sel), 16'hF);

        // start scan: first ON cycle shows digit 0, no frame_done
        enable = 1'b1;
        tick();
        fc = 1;
        chk("first_on_sel", 16'(digit_sel), 16'hE);
        chk("first_on_nib", 16'(nibble_out), 16'h4);
        chk("first_on_fd", 16'(frame_done), 16'h0);
        adv_to(4);
        chk("gap_sel", 16'(digit_sel), 16'hF);
        chk("gap_nib_hold", 16'(nibble_out), 16'h4);
        wait_fd(13);

        // frame 2: mid-frame load, then back-pressured load
        adv_to(6);
        load = 1'b1; load_data = 16'hABCD;
        tick();
        load = 1'b0;
        chk("midload_ready", 16'(ready), 16'h0);
        adv_to(8);
        load = 1'b1; load_data = 16'h5555;
        tick();
        load = 1'b0;
        chk("bp_ready", 16'(ready), 16'h0);
        wait_fd(8);
        chk("commit_nib", 16'(nibble_out), 16'hD);
        chk("commit_ready_low", 16'(ready), 16'h0);
        tick();
        chk("commit_ready_high", 16'(ready), 16'h1);

        // frame 3: arm blanking for digit 2 of the next frame
        adv_to(13);
        blank_mask = 4'b0100;
        wait_fd(4);

        // frame 4: digit 2 slot stays dark, period unchanged
        adv_to(10);
        chk("blank_sel", 16'(digit_sel), 16'hF);
        adv_to(12);
        chk("blank_gap_sel", 16'(digit_sel), 16'hF);
        wait_fd(5);
        blank_mask = 4'b0000;

        // frame 5: drop enable during digit 1 ON
        adv_to(6);
        chk("d1_on_sel", 16'(digit_sel), 16'hD);
        enable = 1'b0;
        tick();
        chk("drop_sel", 16'(digit_sel), 16'hF);
        tick(); tick();
        chk("idle_sel", 16'(digit_sel), 16'hF);
        enable = 1'b1;
        tick();
        chk("restart_sel", 16'(digit_sel), 16'hE);
        chk("restart_nib", 16'(nibble_out), 16'hD);
        chk("restart_fd", 16'(frame_done), 16'h0);

        // reset mid-scan
        tick();
        rst = 1'b1; enable = 1'b0;
        tick(); tick();
        chk("midrst_ready", 16'(ready), 16'h1);
        chk("midrst_sel", 16'(digit_sel), 16'hF);
        chk("midrst_nib", 16'(nibble_out), 16'h0);
        chk("midrst_fd", 16'(frame_done), 16'h0);
        rst = 1'b0;
        tick(); tick();
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
